// File: rtl/axi_write_slave.sv
// AXI-style write responder: accepts one AW and one W beat in either order, commits to a small register file, returns B.
// Optional AXI_WSTRB_EN adds a wstrb byte-lane mask latched alongside wdata.
module axi_write_slave #(
    parameter logic [31:0] BASE_ADDR = 32'hDEAD_BE00,
    parameter int          NUM_REGS  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
`ifdef AXI_WSTRB_EN
    input  logic [3:0]  wstrb,
`endif
    input  logic        wvalid,
    output logic        wready,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    input  logic [3:0]  rd_idx,
    output logic [31:0] rd_data,
    output logic [15:0] wr_count,
    output logic [1:0]  dbg_state
);

    localparam int IW = $clog2(NUM_REGS);

    // Handshake rule: a transfer happens on a posedge where valid and ready are both high;
    // ready is decoded from the state register only, so it never depends on valid.
    typedef enum logic [1:0] {IDLE, GOT_AW, GOT_W, RESP} state_t;

    state_t      state, state_nx;
    logic [31:0] addr_q, data_q;
    logic [31:0] regs [NUM_REGS];
    logic        aw_hs, w_hs, commit, addr_ok;
    logic [31:0] commit_addr, commit_data, off;
    logic [3:0]  commit_strb;
    logic [IW-1:0] widx;
    logic [4:0]  rd_idx_ext;

`ifdef AXI_WSTRB_EN
    logic [3:0] strb_q;
`endif

    assign awready   = (state == IDLE) || (state == GOT_W);
    assign wready    = (state == IDLE) || (state == GOT_AW);
    assign bvalid    = (state == RESP);
    assign dbg_state = state;
    assign aw_hs     = awvalid & awready;
    assign w_hs      = wvalid & wready;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (aw_hs && w_hs) state_nx = RESP;
                else if (aw_hs)    state_nx = GOT_AW;
                else if (w_hs)     state_nx = GOT_W;
            end
            GOT_AW:  if (w_hs)   state_nx = RESP;
            GOT_W:   if (aw_hs)  state_nx = RESP;
            RESP:    if (bready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The final beat may arrive on the commit edge itself, so take it straight from the bus.
    always_comb begin
        commit      = (state != RESP) && (state_nx == RESP);
        commit_addr = (state == GOT_AW) ? addr_q : awaddr;
        commit_data = (state == GOT_W)  ? data_q : wdata;
`ifdef AXI_WSTRB_EN
        commit_strb = (state == GOT_W)  ? strb_q : wstrb;
`else
        commit_strb = 4'hF;
`endif
        off     = commit_addr - BASE_ADDR;
        addr_ok = (off[1:0] == 2'b00) && (off < 32'(4 * NUM_REGS));
        widx    = off[IW+1:2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            bresp    <= 2'b00;
            wr_count <= '0;
`ifdef AXI_WSTRB_EN
            strb_q   <= '0;
`endif
        end else begin
            state <= state_nx;
            if (aw_hs) addr_q <= awaddr;
            if (w_hs) begin
                data_q <= wdata;
`ifdef AXI_WSTRB_EN
                strb_q <= wstrb;
`endif
            end
            if (commit) begin
                bresp <= addr_ok ? 2'b00 : 2'b10;
                if (addr_ok && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (commit && addr_ok) begin
            for (int b = 0; b < 4; b++)
                if (commit_strb[b]) regs[widx][8*b +: 8] <= commit_data[8*b +: 8];
        end
    end

    assign rd_idx_ext = {1'b0, rd_idx};
    assign rd_data    = (rd_idx_ext < 5'(NUM_REGS)) ? regs[rd_idx[IW-1:0]] : 32'h0;

endmodule

// File: tb/tb_axi_write_slave.sv
// Bench for axi_write_slave: directed and random writes against a reference register model,
// B responses checked by a monitor that pops an expected queue.
module tb_axi_write_slave;

    localparam logic [31:0] BASE = 32'hDEAD_BE00;
    localparam int          NR   = 4;

    logic        clk = 0;
    logic        rst = 1;
    logic [31:0] awaddr = '0;
    logic        awvalid = 0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = 4'hF;
    logic        wvalid = 0;
    logic        wready;
    logic        bvalid;
    logic        bready = 0;
    logic [1:0]  bresp;
    logic [3:0]  rd_idx = '0;
    logic [31:0] rd_data;
    logic [15:0] wr_count;
    logic [1:0]  dbg_state;

    axi_write_slave #(.BASE_ADDR(BASE), .NUM_REGS(NR)) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata),
`ifdef AXI_WSTRB_EN
        .wstrb(wstrb),
`endif
        .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .rd_idx(rd_idx), .rd_data(rd_data), .wr_count(wr_count),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [17:0] exp_q[$];
    logic [31:0] m_regs [NR];
    logic [15:0] m_count = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: applies a write by the address rules and queues {bresp, wr_count}.
    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] off;
        logic [1:0]  resp;
        off = addr - BASE;
        if ((off % 4) == 0 && off < 4 * NR) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) m_regs[off / 4][8*b +: 8] = data[8*b +: 8];
            if (m_count != 16'hFFFF) m_count = m_count + 1;
            resp = 2'b00;
        end else begin
            resp = 2'b10;
        end
        exp_q.push_back({resp, m_count});
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_count = '0;
    endtask

    task automatic check_all_regs(input string name);
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i);
            #1;
            check(name, rd_data, (i < NR) ? m_regs[i] : 32'h0);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done = 0, w_done = 0;
        int cyc = 0;
        int n = 0;
        logic [1:0] first_resp;
        model_write(addr, data, strb);
        while (!(aw_done && w_done)) begin
            @(negedge clk);
            awaddr  = addr;
            wdata   = data;
            wstrb   = strb;
            awvalid = !aw_done && cyc >= aw_dly;
            wvalid  = !w_done && cyc >= w_dly;
            #1;
            if (aw_done && !w_done)  check("got_aw_ready", {awready, wready}, 2'b01);
            if (w_done && !aw_done)  check("got_w_ready", {awready, wready}, 2'b10);
            if (!aw_done && !w_done) check("idle_ready", {awready, wready}, 2'b11);
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready)   w_done = 1;
            cyc++;
            if (cyc > 60) begin
                check("hs_timeout", 1, 0);
                break;
            end
        end
        @(negedge clk);
        awvalid = 0;
        wvalid  = 0;
        bready  = (b_dly == 0);
        #1;
        check("b_latency", bvalid, 1);
        first_resp = bresp;
        while (n < 60) begin
            check("b_hold", {bvalid, bresp}, {1'b1, first_resp});
            if (bready) break;
            @(negedge clk);
            n++;
            bready = (n >= b_dly);
            #1;
        end
        @(negedge clk);
        bready = 0;
        #1;
        check("idle_after_b", {bvalid, awready, wready}, 3'b011);
        rd_idx = 4'($urandom_range(0, 15));
        #1;
        check("rd_data", rd_data, (rd_idx < NR) ? m_regs[rd_idx] : 32'h0);
    endtask

    // Monitor: pops an expected response on every B handshake.
    always begin
        logic [17:0] e;
        @(negedge clk);
        #2;
        if (!rst && bvalid) begin
            check("resp_ready_low", {awready, wready}, 2'b00);
            if (bready) begin
                if (exp_q.size() == 0) begin
                    check("b_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("bresp", bresp, e[17:16]);
                    check("wr_count", wr_count, e[15:0]);
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  s;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        check("rst_b", {bvalid, bresp}, 3'b000);
        check("rst_ready", {awready, wready}, 2'b11);
        check("rst_count", wr_count, 0);
        check_all_regs("rst_regs");

        do_write(32'hDEAD_BE04, 32'h1234_5678, 4'hF, 0, 0, 0);
        check_all_regs("t1_regs");
        do_write(32'hDEAD_BE0C, 32'hCAFE_F00D, 4'hF, 3, 0, 0);
        check_all_regs("t2_regs");
        do_write(32'hDEAD_BEEF, 32'h5555_AAAA, 4'hF, 0, 1, 0);
        check_all_regs("t3_regs");
        do_write(32'hDEAD_BE08, 32'hA5A5_0F0F, 4'hF, 1, 2, 5);
        check_all_regs("t4_regs");
        do_write(32'hDEAD_BE10, 32'h0BAD_0BAD, 4'hF, 0, 0, 1);
        do_write(32'hDEAD_BDFC, 32'h0BAD_0BAD, 4'hF, 0, 0, 0);
        check_all_regs("edge_regs");
`ifdef AXI_WSTRB_EN
        do_write(32'hDEAD_BE00, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        do_write(32'hDEAD_BE00, 32'h0000_0000, 4'b0101, 0, 0, 0);
        rd_idx = 0;
        #1;
        check("strb_reg0", rd_data, 32'hFF00_FF00);
        do_write(32'hDEAD_BE04, 32'h0000_0000, 4'b0000, 0, 0, 0);
        check_all_regs("strb_regs");
`endif

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0, 1:    a = BASE + 4 * $urandom_range(0, NR - 1);
                2:       a = BASE + $urandom_range(0, 31);
                default: a = BASE - $urandom_range(1, 16);
            endcase
`ifdef AXI_WSTRB_EN
            s = 4'($urandom_range(0, 15));
`else
            s = 4'hF;
`endif
            do_write(a, $urandom, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        check_all_regs("rand_regs");

        @(negedge clk);
        awaddr  = BASE + 8;
        awvalid = 1;
        @(negedge clk);
        awvalid = 0;
        #1;
        check("pre_rst_got_aw", {awready, wready}, 2'b01);
        rst = 1;
        #1;
        check("mid_rst_out", {bvalid, awready, wready}, 3'b011);
        @(negedge clk);
        rst = 0;
        model_reset();
        #1;
        check("mid_rst_count", wr_count, 0);
        check_all_regs("mid_rst_regs");
        do_write(32'hDEAD_BE0C, 32'h7777_1111, 4'hF, 0, 2, 1);
        check_all_regs("post_rst_regs");

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
